// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor.
// Holds the one-hot lamp encodings, the per-road lamp class, the phase codes,
// the monitor FSM state type and the default phase lengths. The default
// lengths are shared with the light controller.
package traffic_pkg;

  // One-hot lamp encodings as seen on light_a / light_b
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Per-road classification produced by light_decode
  typedef enum logic [1:0] {
    LAMP_R = 2'd0,
    LAMP_Y = 2'd1,
    LAMP_G = 2'd2,
    LAMP_X = 2'd3
  } lamp_e;

  typedef logic [2:0] phase_t;

  localparam phase_t P0            = 3'd0;  // (G,R)
  localparam phase_t P1            = 3'd1;  // (Y,R)
  localparam phase_t P2            = 3'd2;  // (R,R) after P1
  localparam phase_t P3            = 3'd3;  // (R,G)
  localparam phase_t P4            = 3'd4;  // (R,Y)
  localparam phase_t P5            = 3'd5;  // (R,R) after P4
  localparam phase_t PHASE_UNKNOWN = 3'd7;

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } state_e;

  localparam int unsigned DEF_GREEN_LEN  = 6;
  localparam int unsigned DEF_YELLOW_LEN = 2;
  localparam int unsigned DEF_ALLRED_LEN = 2;

  // Legal successor in the P0..P5 ring
  function automatic phase_t next_phase(input phase_t p);
    phase_t nxt;
    case (p)
      P0:      nxt = P1;
      P1:      nxt = P2;
      P2:      nxt = P3;
      P3:      nxt = P4;
      P4:      nxt = P5;
      P5:      nxt = P0;
      default: nxt = PHASE_UNKNOWN;
    endcase
    return nxt;
  endfunction

  // Required dwell of a phase given the three configured lengths
  function automatic logic [3:0] req_len(input phase_t p,
                                         input logic [3:0] g_len,
                                         input logic [3:0] y_len,
                                         input logic [3:0] r_len);
    logic [3:0] len;
    case (p)
      P0, P3:  len = g_len;
      P1, P4:  len = y_len;
      P2, P5:  len = r_len;
      default: len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/light_decode.sv
// Combinational decode of one road's lamp vector.
// Ports:
//   lamp_i  [2:0]  raw lamp vector (one-hot R/Y/G expected)
//   valid_o        1 when lamp_i is exactly one of RED/YELLOW/GREEN
//   class_o        R/Y/G class, LAMP_X for any non-one-hot value
module light_decode
  import traffic_pkg::*;
(
  input  logic [2:0] lamp_i,
  output logic       valid_o,
  output lamp_e      class_o
);

  // One-hot check and colour classification
  always_comb begin
    valid_o = 1'b1;
    class_o = LAMP_X;
    case (lamp_i)
      RED:     class_o = LAMP_R;
      YELLOW:  class_o = LAMP_Y;
      GREEN:   class_o = LAMP_G;
      default: begin
        valid_o = 1'b0;
        class_o = LAMP_X;
      end
    endcase
  end

endmodule

// File: rtl/traffic_monitor.sv
// Passive monitor of a two-road traffic light controller.
// Locks onto the phase ring P0..P5, checks lamp encoding, conflicting
// greens/yellows, phase order and phase dwell, and counts clean cycles.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   light_a/light_b  lamp vectors of road A / road B
//   phase            decoded phase 0..5, 7 when unknown
//   synced           monitor locked onto the sequence
//   err_encoding, err_conflict, err_sequence, err_timing  one-cycle pulses
//   err_sticky       OR of all pulses, held until reset
//   cycle_cnt        count of complete error-free cycles (wraps)
// All outputs are registered: a sample taken at edge k is visible after edge k.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_LEN  = DEF_GREEN_LEN,
  parameter int unsigned YELLOW_LEN = DEF_YELLOW_LEN,
  parameter int unsigned ALLRED_LEN = DEF_ALLRED_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_a,
  input  logic [2:0] light_b,
  output logic [2:0] phase,
  output logic       synced,
  output logic       err_encoding,
  output logic       err_conflict,
  output logic       err_sequence,
  output logic       err_timing,
  output logic       err_sticky,
  output logic [7:0] cycle_cnt
);

  localparam logic [3:0] G_LEN = 4'(GREEN_LEN);
  localparam logic [3:0] Y_LEN = 4'(YELLOW_LEN);
  localparam logic [3:0] R_LEN = 4'(ALLRED_LEN);

  logic       valid_a_s, valid_b_s;
  lamp_e      class_a_s, class_b_s;
  logic [3:0] pair_s;
  logic       enc_err_s, conf_err_s;
  logic       samp_rr_s;
  phase_t     samp_phase_s;
  phase_t     succ_s;
  logic       unchanged_s, legal_s, short_s;
  logic [3:0] cur_len_s, dwell_inc_s;

  state_e     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [3:0] dwell_q, dwell_d;
  logic       clean_q, clean_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_enc_q, err_enc_d;
  logic       err_conf_q, err_conf_d;
  logic       err_seq_q, err_seq_d;
  logic       err_tim_q, err_tim_d;
  logic       sticky_q, sticky_d;
  logic       synced_q, synced_d;

  light_decode u_dec_a (
    .lamp_i  (light_a),
    .valid_o (valid_a_s),
    .class_o (class_a_s)
  );

  light_decode u_dec_b (
    .lamp_i  (light_b),
    .valid_o (valid_b_s),
    .class_o (class_b_s)
  );

  assign pair_s     = {class_a_s, class_b_s};
  assign enc_err_s  = ~valid_a_s | ~valid_b_s;
  assign conf_err_s = ~enc_err_s & (class_a_s != LAMP_R) & (class_b_s != LAMP_R);

  // Map the road pair onto a phase; (R,R) is resolved later from history
  always_comb begin
    samp_rr_s    = 1'b0;
    samp_phase_s = PHASE_UNKNOWN;
    case (pair_s)
      {LAMP_G, LAMP_R}: samp_phase_s = P0;
      {LAMP_Y, LAMP_R}: samp_phase_s = P1;
      {LAMP_R, LAMP_G}: samp_phase_s = P3;
      {LAMP_R, LAMP_Y}: samp_phase_s = P4;
      {LAMP_R, LAMP_R}: samp_rr_s    = 1'b1;
      default:          samp_phase_s = PHASE_UNKNOWN;
    endcase
  end

  assign succ_s      = next_phase(phase_q);
  assign cur_len_s   = req_len(phase_q, G_LEN, Y_LEN, R_LEN);
  // An (R,R) sample continues P2/P5 and is the legal successor of P1/P4
  assign unchanged_s = samp_rr_s ? ((phase_q == P2) || (phase_q == P5))
                                 : (samp_phase_s == phase_q);
  assign legal_s     = samp_rr_s ? ((succ_s == P2) || (succ_s == P5))
                                 : (samp_phase_s == succ_s);
  assign short_s     = (dwell_q < cur_len_s);
  assign dwell_inc_s = (dwell_q == 4'd15) ? 4'd15 : (dwell_q + 4'd1);

  // Next-state, dwell, error and cycle-count logic
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    dwell_d    = dwell_q;
    clean_d    = clean_q;
    cnt_d      = cnt_q;
    err_enc_d  = 1'b0;
    err_conf_d = 1'b0;
    err_seq_d  = 1'b0;
    err_tim_d  = 1'b0;

    if (enc_err_s || conf_err_s) begin
      // Lamp-level faults override every sequence/timing check
      err_enc_d  = enc_err_s;
      err_conf_d = conf_err_s;
      state_d    = UNSYNC;
      phase_d    = PHASE_UNKNOWN;
      dwell_d    = 4'd0;
      clean_d    = 1'b0;
    end else if (state_q == UNSYNC) begin
      if (samp_rr_s) begin
        phase_d = PHASE_UNKNOWN;
        dwell_d = 4'd0;
      end else begin
        state_d = TRACK;
        phase_d = samp_phase_s;
        dwell_d = 4'd1;
        // A cycle only counts if it was observed from the start of P0
        clean_d = (samp_phase_s == P0);
      end
    end else if (unchanged_s) begin
      dwell_d = dwell_inc_s;
      // Fires exactly once: dwell passes the required length only once
      if (dwell_q == cur_len_s) begin
        err_tim_d = 1'b1;
        clean_d   = 1'b0;
      end else begin
        err_tim_d = 1'b0;
      end
    end else begin
      err_tim_d = short_s;
      if (legal_s) begin
        phase_d = succ_s;
        dwell_d = 4'd1;
        if (succ_s == P0) begin
          if (clean_q && !short_s) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
          clean_d = 1'b1;
        end else begin
          clean_d = clean_q & ~short_s;
        end
      end else begin
        err_seq_d = 1'b1;
        if (samp_rr_s) begin
          state_d = UNSYNC;
          phase_d = PHASE_UNKNOWN;
          dwell_d = 4'd0;
          clean_d = 1'b0;
        end else begin
          phase_d = samp_phase_s;
          dwell_d = 4'd1;
          clean_d = (samp_phase_s == P0);
        end
      end
    end

    synced_d = (state_d == TRACK);
    sticky_d = sticky_q | err_enc_d | err_conf_d | err_seq_d | err_tim_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNSYNC;
      phase_q    <= PHASE_UNKNOWN;
      dwell_q    <= 4'd0;
      clean_q    <= 1'b0;
      cnt_q      <= 8'd0;
      err_enc_q  <= 1'b0;
      err_conf_q <= 1'b0;
      err_seq_q  <= 1'b0;
      err_tim_q  <= 1'b0;
      sticky_q   <= 1'b0;
      synced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      dwell_q    <= dwell_d;
      clean_q    <= clean_d;
      cnt_q      <= cnt_d;
      err_enc_q  <= err_enc_d;
      err_conf_q <= err_conf_d;
      err_seq_q  <= err_seq_d;
      err_tim_q  <= err_tim_d;
      sticky_q   <= sticky_d;
      synced_q   <= synced_d;
    end
  end

  assign phase        = phase_q;
  assign synced       = synced_q;
  assign err_encoding = err_enc_q;
  assign err_conflict = err_conf_q;
  assign err_sequence = err_seq_q;
  assign err_timing   = err_tim_q;
  assign err_sticky   = sticky_q;
  assign cycle_cnt    = cnt_q;

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter GREEN_LEN, default 6: required green dwell in clock cycles (legal range 1..14).
REQ-002 Parameter YELLOW_LEN, default 2: required yellow dwell in clock cycles (legal range 1..14).
REQ-003 Parameter ALLRED_LEN, default 2: required all-red dwell in clock cycles (legal range 1..14).
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high; the ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 light_a  input  3  road A lamps; 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-008 light_b  input  3  road B lamps; same encoding as light_a.
REQ-009 phase  output  3  decoded phase 0..5; 7 = unknown.
REQ-010 synced  output  1  monitor is locked to the phase sequence.
REQ-011 err_encoding, err_conflict, err_sequence, err_timing  output  1 each  single-cycle error pulses.
REQ-012 err_sticky  output  1  OR of all error pulses, held until rst.
REQ-013 cycle_cnt  output  8  count of complete, legal phase cycles; wraps 255->0.

Function
REQ-014 All outputs SHALL be registered; a pattern sampled at edge k SHALL be reflected in the outputs after edge k, giving one-cycle latency.
REQ-015 Lamp decode SHALL classify each road as R/Y/G; any non-one-hot value (000, 011, 111, ...) SHALL pulse err_encoding and force synced=0 and phase=7.
REQ-016 If both roads are non-red and both are validly encoded, the monitor SHALL pulse err_conflict and force synced=0 and phase=7.
REQ-017 Phase map SHALL be: P0=(G,R), P1=(Y,R), P2=(R,R) after P1, P3=(R,G), P4=(R,Y), P5=(R,R) after P4; legal order is P0->P1->P2->P3->P4->P5->P0.
REQ-018 FSM SHALL have states UNSYNC and TRACK; UNSYNC->TRACK on the first sample that is P0, P1, P3 or P4, which loads phase and sets dwell=1.
REQ-019 In UNSYNC, an (R,R) sample SHALL be treated as ambiguous: the FSM stays in UNSYNC, phase=7, and err_sequence and err_timing are suppressed.
REQ-020 In TRACK, the dwell counter SHALL be 4 bits, increment while the pattern is unchanged, and saturate at 15.
REQ-021 Overrun: in the cycle dwell would exceed the phase's required length, err_timing SHALL pulse once per phase occurrence.
REQ-022 Short dwell: on a pattern change with dwell < required length, err_timing SHALL pulse.
REQ-023 Illegal successor: on a pattern change to a phase other than the legal successor, err_sequence SHALL pulse; the FSM SHALL relock if the new phase is unambiguous, otherwise go to UNSYNC.
REQ-024 cycle_cnt SHALL increment on a P5->P0 change only if all six phases of that cycle completed with no error pulse.
REQ-025 Simultaneous conditions SHALL follow this priority: encoding/conflict checks are applied first and suppress sequence/timing checks in that cycle; multiple pulses of the same priority may assert together.

Reset
REQ-026 While rst=1 at an edge, the monitor SHALL set: FSM=UNSYNC, phase=7, synced=0, every err_* output=0, err_sticky=0, cycle_cnt=0, dwell=0.
REQ-027 A reset asserted mid-operation SHALL take effect at the next edge, and the first post-reset sample SHALL be evaluated as in UNSYNC.

Structure
REQ-028 Package traffic_pkg SHALL hold the lamp encodings (RED/YELLOW/GREEN), the phase codes P0..P5 and PHASE_UNKNOWN, the FSM state type, and the default lengths shared with the light controller.
REQ-029 One sub-module, light_decode, SHALL implement the purely combinational per-road one-hot check and R/Y/G classification, instantiated twice.

Verification
REQ-030 Bench SHALL drive a legal sequence with lengths 6/2/2/6/2/2 for 3 full cycles from reset -> synced=1 from cycle 2, cycle_cnt=3, err_sticky=0.
REQ-031 Bench SHALL drive light_a=001 and light_b=001 for one cycle during P3 -> err_conflict pulses 1 cycle, synced=0, phase=7, err_sticky=1.
REQ-032 Bench SHALL drive light_a=011 for one cycle -> err_encoding pulses, FSM goes to UNSYNC, and relocks on the next P3 or P4 sample.
REQ-033 Bench SHALL drive P0 for 6 cycles, then (R,R) -> err_sequence pulses, FSM goes to UNSYNC, cycle_cnt unchanged.
REQ-034 Bench SHALL hold P0 for 7 cycles -> err_timing pulses exactly once, on the 7th sample; hold P1 for 1 cycle -> err_timing on the P1->P2 change.
REQ-035 Bench SHALL assert rst for 1 cycle while cycle_cnt=2 during P4 -> after the edge all outputs equal the REQ-026 values; phase=7 until the first unambiguous sample.
